// File: rtl/fmc_adc_acq_buffer_if.sv
// Port bundle for the ADC acquisition buffer: sample stream, capture control/status and readout.
// The master drives samples and commands; the slave (the buffer) returns status and read data.
interface fmc_adc_acq_buffer_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic [NUM_CH*DATA_W-1:0]     adc_data_in;
  logic [NUM_CH-1:0]            adc_ov_in;
  logic                         adc_valid_in;
  logic                         trigger;
  logic                         sw_trigger;
  logic                         arm;
  logic                         abort;
  logic [DEPTH_LOG2-1:0]        pre_samples;
  logic [DEPTH_LOG2-1:0]        post_samples;
  logic                         busy;
  logic                         armed;
  logic                         done;
  logic [DEPTH_LOG2-1:0]        trig_addr;
  logic [NUM_CH-1:0]            ov_sticky;
  logic                         rd_en;
  logic [DEPTH_LOG2-1:0]        rd_addr;
  logic [NUM_CH*(DATA_W+1)-1:0] rd_data;
  logic                         rd_valid;

  modport master (
    output adc_data_in, adc_ov_in, adc_valid_in, trigger, sw_trigger, arm, abort,
           pre_samples, post_samples, rd_en, rd_addr,
    input  busy, armed, done, trig_addr, ov_sticky, rd_data, rd_valid
  );

  modport slave (
    input  adc_data_in, adc_ov_in, adc_valid_in, trigger, sw_trigger, arm, abort,
           pre_samples, post_samples, rd_en, rd_addr,
    output busy, armed, done, trig_addr, ov_sticky, rd_data, rd_valid
  );
endinterface

// File: rtl/fmc_adc_acq_buffer.sv
// Multi-channel ADC capture into a circular RAM with pre/post-trigger windows and
// trigger-relative readout.
module fmc_adc_acq_buffer #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input logic                sys_clk,
  input logic                rst,
  fmc_adc_acq_buffer_if.slave bus
);
  localparam int DEPTH  = 2**DEPTH_LOG2;
  localparam int WORD_W = NUM_CH*(DATA_W+1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [DEPTH_LOG2:0]   WIDE_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   WIDE_DEPTH = DEPTH;

  typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST, DONE} state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, pre_lat, post_eff, post_cnt, trig_addr_q;
  logic [NUM_CH-1:0]     ov_sticky_q;
  logic                  trigger_d, pending;
  logic                  idle_or_done, start, wr_en, trig_event, trig_hit;
  logic [DEPTH_LOG2:0]   post_min1, room;
  logic [DEPTH_LOG2-1:0] post_eff_d, rd_ptr;
  logic [WORD_W-1:0]     wr_word, rd_data_q;
  logic                  rd_valid_q;
  logic [WORD_W-1:0]     mem [DEPTH];

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign start        = idle_or_done && bus.arm && !bus.abort;
  assign wr_en        = bus.adc_valid_in && (state inside {PRE_FILL, ARMED, POST});
  assign trig_event   = (bus.trigger & ~trigger_d) | bus.sw_trigger;
  assign trig_hit     = (state == ARMED) && bus.adc_valid_in && (trig_event || pending);

  // Post window is at least the trigger sample and never large enough to overwrite the pre window.
  assign post_min1  = (bus.post_samples == '0) ? WIDE_ONE : {1'b0, bus.post_samples};
  assign room       = WIDE_DEPTH - {1'b0, bus.pre_samples};
  assign post_eff_d = (post_min1 < room) ? post_min1[DEPTH_LOG2-1:0] : room[DEPTH_LOG2-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (bus.arm) state_nxt = (bus.pre_samples == '0) ? ARMED : PRE_FILL;
      // wr_ptr starts at zero on arm, so it doubles as the pre-fill counter.
      PRE_FILL:   if (bus.adc_valid_in && (wr_ptr + PTR_ONE == pre_lat)) state_nxt = ARMED;
      ARMED:      if (trig_hit) state_nxt = (post_eff == PTR_ONE) ? DONE : POST;
      POST:       if (bus.adc_valid_in && (post_cnt + PTR_ONE == post_eff)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (bus.abort) state_nxt = IDLE;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      pre_lat     <= '0;
      post_eff    <= '0;
      post_cnt    <= '0;
      trig_addr_q <= '0;
      ov_sticky_q <= '0;
      trigger_d   <= 1'b0;
      pending     <= 1'b0;
    end else begin
      state     <= state_nxt;
      trigger_d <= bus.trigger;
      if (bus.abort) begin
        pending <= 1'b0;
      end else if (start) begin
        pre_lat     <= bus.pre_samples;
        post_eff    <= post_eff_d;
        ov_sticky_q <= '0;
        wr_ptr      <= '0;
        pending     <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr      <= wr_ptr + PTR_ONE;
          ov_sticky_q <= ov_sticky_q | bus.adc_ov_in;
        end
        if (trig_hit) begin
          trig_addr_q <= wr_ptr;
          post_cnt    <= PTR_ONE;
          pending     <= 1'b0;
        end else if ((state == ARMED) && trig_event) begin
          pending <= 1'b1;
        end
        if ((state == POST) && bus.adc_valid_in) post_cnt <= post_cnt + PTR_ONE;
      end
    end
  end

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr_word[i*(DATA_W+1) +: DATA_W+1] = {bus.adc_ov_in[i], bus.adc_data_in[i*DATA_W +: DATA_W]};
  end

  // NOTE: the sample RAM has no reset so it maps onto block RAM; only its read register is reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  // Readout is indexed from the oldest pre-trigger sample.
  assign rd_ptr = trig_addr_q - pre_lat + bus.rd_addr;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem[rd_ptr];
    end
  end

  assign bus.busy      = state inside {PRE_FILL, ARMED, POST};
  assign bus.armed     = (state == ARMED);
  assign bus.done      = (state == DONE);
  assign bus.trig_addr = trig_addr_q;
  assign bus.ov_sticky = ov_sticky_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
endmodule
